btn_conditioner: RTL and testbench

//  N-channel push-button conditioner that replaces the per-button debouncer instances feeding core.

---
 rtl/btn_conditioner_pkg.sv | 18 +
 rtl/btn_conditioner_channel.sv | 173 +++++++++++++++++
 rtl/btn_conditioner.sv | 60 ++++++
 tb/tb_btn_conditioner.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// btn_conditioner_pkg
//   Shared definitions for the push-button conditioner: the per-channel
//   debounce FSM state encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package btn_conditioner_pkg;

    localparam int BTN_STATE_W = 2;

    typedef enum logic [BTN_STATE_W-1:0] {
        ST_IDLE     = 2'd0,
        ST_DB_PRESS = 2'd1,
        ST_HELD     = 2'd2,
        ST_DB_REL   = 2'd3
    } btn_state_t;

endpackage

// File: rtl/btn_conditioner_channel.sv
// -----------------------------------------------------------------------------
// btn_conditioner_channel
//   One button channel: 2-flop synchroniser, debounce FSM, auto-repeat timer
//   and (optionally) a long-press hold timer. All outputs are registered.
//
//   Optional feature macro: BTN_LONGPRESS_EN
//     defined   -> hold counter built, o_long_press pulses once per hold
//     undefined -> no hold counter, o_long_press tied 0
//
// Ports
//   i_clk        in  1  system clock
//   i_rst_n      in  1  asynchronous active-low reset
//   i_btn        in  1  raw asynchronous button, active-high
//   o_dpb        out 1  debounced level
//   o_press      out 1  1-cycle pulse on accepted press
//   o_release    out 1  1-cycle pulse on accepted release
//   o_rpt        out 1  pulse on press, then auto-repeat while held
//   o_long_press out 1  1-cycle pulse when the hold reaches LONG_CYCLES
// -----------------------------------------------------------------------------
module btn_conditioner_channel #(
    parameter int unsigned CNT_W       = 28,
    parameter int unsigned DEB_CYCLES  = 2**20,
    parameter int unsigned RPT_FIRST   = 2**24,
    parameter int unsigned RPT_PERIOD  = 2**22,
    parameter int unsigned LONG_CYCLES = 2**26,
    parameter bit          RPT_EN      = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_dpb,
    output logic o_press,
    output logic o_release,
    output logic o_rpt,
    output logic o_long_press
);
    import btn_conditioner_pkg::*;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] FIRST_LAST  = CNT_W'(RPT_FIRST - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(RPT_PERIOD - 1);

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    btn_state_t       r_state;
    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_deb_cnt;
    logic [CNT_W-1:0] r_rpt_cnt;
    logic             r_rpt_after_first;
    logic             r_dpb;
    logic             r_press;
    logic             r_release;
    logic             r_rpt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1              <= 1'b0;
            r_s2              <= 1'b0;
            r_state           <= ST_IDLE;
            r_deb_cnt         <= '0;
            r_rpt_cnt         <= '0;
            r_rpt_after_first <= 1'b0;
            r_dpb             <= 1'b0;
            r_press           <= 1'b0;
            r_release         <= 1'b0;
            r_rpt             <= 1'b0;
        end else begin
            r_s1      <= i_btn;
            r_s2      <= r_s1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_rpt     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_s2) begin
                        r_state   <= ST_DB_PRESS;
                        r_deb_cnt <= '0;
                    end
                end
                ST_DB_PRESS: begin
                    if (!r_s2) begin
                        r_state <= ST_IDLE;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        r_state           <= ST_HELD;
                        r_dpb             <= 1'b1;
                        r_press           <= 1'b1;
                        r_rpt             <= 1'b1;
                        r_rpt_cnt         <= '0;
                        r_rpt_after_first <= 1'b0;
                    end else begin
                        r_deb_cnt <= sat_inc(r_deb_cnt);
                    end
                end
                ST_HELD: begin
                    if (!r_s2) begin
                        r_state   <= ST_DB_REL;
                        r_deb_cnt <= '0;
                    end
                    // Repeat timer reloads on each pulse; the first interval
                    // is RPT_FIRST, every later one RPT_PERIOD.
                    if (RPT_EN) begin
                        if (r_rpt_cnt == (r_rpt_after_first ? PERIOD_LAST : FIRST_LAST)) begin
                            r_rpt             <= 1'b1;
                            r_rpt_cnt         <= '0;
                            r_rpt_after_first <= 1'b1;
                        end else begin
                            r_rpt_cnt <= sat_inc(r_rpt_cnt);
                        end
                    end
                end
                ST_DB_REL: begin
                    // Repeat timer is frozen here; a glitch returns to HELD
                    // and the schedule resumes where it stopped.
                    if (r_s2) begin
                        r_state <= ST_HELD;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        r_state   <= ST_IDLE;
                        r_dpb     <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_deb_cnt <= sat_inc(r_deb_cnt);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_dpb     = r_dpb;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_rpt     = r_rpt;

`ifdef BTN_LONGPRESS_EN
    localparam logic [CNT_W-1:0] LONG_TGT  = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    logic             w_press_accept;
    logic [CNT_W-1:0] r_long_cnt;
    logic             r_long;

    assign w_press_accept = (r_state == ST_DB_PRESS) && r_s2 && (r_deb_cnt == DEB_LAST);

    // Hold counter runs through HELD and DB_REL and parks at LONG_CYCLES,
    // so the pulse fires only once per hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_long_cnt <= '0;
            r_long     <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (w_press_accept) begin
                r_long_cnt <= '0;
            end else if ((r_state == ST_HELD || r_state == ST_DB_REL) &&
                         (r_long_cnt != LONG_TGT)) begin
                r_long_cnt <= sat_inc(r_long_cnt);
                r_long     <= (r_long_cnt == LONG_LAST);
            end
        end
    end

    assign o_long_press = r_long;
`else
    logic w_unused_long;
    assign w_unused_long = |LONG_CYCLES;
    assign o_long_press  = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   N-channel push-button conditioner placed between the board buttons and the
//   game core. Each channel is an independent btn_conditioner_channel.
//
//   Optional feature macro: BTN_LONGPRESS_EN (long-press pulse per channel;
//   when undefined o_long_press is constant 0, port list unchanged).
//
// Ports
//   i_clk        in  1     system clock
//   i_rst_n      in  1     asynchronous active-low reset
//   i_btn        in  N_CH  raw asynchronous buttons, active-high
//   o_dpb        out N_CH  debounced levels
//   o_press      out N_CH  1-cycle pulse on accepted press
//   o_release    out N_CH  1-cycle pulse on accepted release
//   o_rpt        out N_CH  pulse on press, then auto-repeat (RPT_MASK bit set)
//   o_long_press out N_CH  1-cycle pulse once per hold at LONG_CYCLES
// -----------------------------------------------------------------------------
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned     N_CH        = 3,
    parameter int unsigned     CNT_W       = 28,
    parameter int unsigned     DEB_CYCLES  = 2**20,
    parameter int unsigned     RPT_FIRST   = 2**24,
    parameter int unsigned     RPT_PERIOD  = 2**22,
    parameter logic [N_CH-1:0] RPT_MASK    = {N_CH{1'b1}},
    parameter int unsigned     LONG_CYCLES = 2**26
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_dpb,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_rpt,
    output logic [N_CH-1:0] o_long_press
);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        btn_conditioner_channel #(
            .CNT_W       (CNT_W),
            .DEB_CYCLES  (DEB_CYCLES),
            .RPT_FIRST   (RPT_FIRST),
            .RPT_PERIOD  (RPT_PERIOD),
            .LONG_CYCLES (LONG_CYCLES),
            .RPT_EN      (RPT_MASK[gi])
        ) u_ch (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_btn        (i_btn[gi]),
            .o_dpb        (o_dpb[gi]),
            .o_press      (o_press[gi]),
            .o_release    (o_release[gi]),
            .o_rpt        (o_rpt[gi]),
            .o_long_press (o_long_press[gi])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;
    localparam int N_CH   = 3;
    localparam int CNT_W  = 8;
    localparam int DEB    = 4;
    localparam int FIRST  = 10;
    localparam int PERIOD = 5;
    localparam int LONG   = 20;
    localparam logic [N_CH-1:0] MASK = 3'b101;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] btn = '0;
    logic [N_CH-1:0] dpb, press, rel, rpt, lng;

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_CH(N_CH), .CNT_W(CNT_W), .DEB_CYCLES(DEB), .RPT_FIRST(FIRST),
        .RPT_PERIOD(PERIOD), .RPT_MASK(MASK), .LONG_CYCLES(LONG)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn), .o_dpb(dpb), .o_press(press),
        .o_release(rel), .o_rpt(rpt), .o_long_press(lng)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a channel's level flips once the synced sample has
    // disagreed with it for DEB+1 consecutive edges. While pressed, repeat
    // time accumulates on edges where no disagreement run is in progress;
    // hold time accumulates on every pressed edge.
    int m_s1[N_CH], m_s2[N_CH], m_dpb[N_CH], m_run[N_CH], m_hn[N_CH], m_ln[N_CH];
    logic [N_CH-1:0] e_press, e_rel, e_rpt, e_lng;

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_dpb[c] = 0; m_run[c] = 0; m_hn[c] = 0; m_ln[c] = 0;
        end
        e_press = '0; e_rel = '0; e_rpt = '0; e_lng = '0;
    endtask

    task automatic model_step();
        e_press = '0; e_rel = '0; e_rpt = '0; e_lng = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (m_dpb[c] != 0) begin
                if (m_run[c] == 0) begin
                    m_hn[c]++;
                    if (MASK[c] && (m_hn[c] == FIRST ||
                        (m_hn[c] > FIRST && (m_hn[c] - FIRST) % PERIOD == 0)))
                        e_rpt[c] = 1'b1;
                end
                m_ln[c]++;
`ifdef BTN_LONGPRESS_EN
                if (m_ln[c] == LONG) e_lng[c] = 1'b1;
`endif
            end
            if (m_s2[c] != m_dpb[c]) begin
                m_run[c]++;
                if (m_run[c] == DEB + 1) begin
                    m_run[c] = 0;
                    m_dpb[c] = m_s2[c];
                    if (m_dpb[c] != 0) begin
                        e_press[c] = 1'b1; e_rpt[c] = 1'b1; m_hn[c] = 0; m_ln[c] = 0;
                    end else begin
                        e_rel[c] = 1'b1;
                    end
                end
            end else begin
                m_run[c] = 0;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = int'(btn[c]);
        end
    endtask

    task automatic compare(input string ph);
        logic [N_CH-1:0] ed;
        for (int c = 0; c < N_CH; c++) ed[c] = (m_dpb[c] != 0);
        chk({ph, ".dpb"},   32'(dpb),   32'(ed));
        chk({ph, ".press"}, 32'(press), 32'(e_press));
        chk({ph, ".rel"},   32'(rel),   32'(e_rel));
        chk({ph, ".rpt"},   32'(rpt),   32'(e_rpt));
        chk({ph, ".long"},  32'(lng),   32'(e_lng));
    endtask

    // Event log of the current directed test: edge index relative to the
    // first cycle() call of the test.
    int jj;
    int q_press[N_CH][$], q_rel[N_CH][$], q_rpt[N_CH][$], q_lng[N_CH][$];
    int cnt_dpb[N_CH];

    // Called at a falling edge: drive, let the rising edge happen, check.
    task automatic cycle(input logic [N_CH-1:0] b, input string ph);
        btn = b;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare(ph);
        for (int c = 0; c < N_CH; c++) begin
            if (press[c]) q_press[c].push_back(jj);
            if (rel[c])   q_rel[c].push_back(jj);
            if (rpt[c])   q_rpt[c].push_back(jj);
            if (lng[c])   q_lng[c].push_back(jj);
            if (dpb[c])   cnt_dpb[c]++;
        end
        jj++;
    endtask

    task automatic clear_log();
        jj = 0;
        for (int c = 0; c < N_CH; c++) begin
            q_press[c].delete(); q_rel[c].delete(); q_rpt[c].delete(); q_lng[c].delete();
            cnt_dpb[c] = 0;
        end
    endtask

    task automatic start_test();
        repeat (12) cycle('0, "idle");
        clear_log();
    endtask

    task automatic chk_q(input string tag, input int got[$], input int exp[$]);
        chk({tag, ".count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp[i]));
    endtask

    // Called at a falling edge; asserts reset between clock edges.
    task automatic apply_reset(input string ph);
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare({ph, ".async"});
        @(negedge clk);
        @(negedge clk);
        compare({ph, ".inreset"});
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int e[$];
        logic [N_CH-1:0] rb;
        int hold_left[N_CH];

        model_reset();
        @(negedge clk);
        compare("reset");
        rst_n = 1'b1;

        // 1: ch0 held 30 cycles
        start_test();
        for (int i = 0; i < 45; i++) cycle((i < 30) ? 3'b001 : 3'b000, "t1");
        e = {6};                 chk_q("t1.press0", q_press[0], e);
        e = {6, 16, 21, 26, 31}; chk_q("t1.rpt0",   q_rpt[0],   e);
        e = {36};                chk_q("t1.rel0",   q_rel[0],   e);
        chk("t1.dpb0_cycles", 32'(cnt_dpb[0]), 32'd30);

        // 2: bounce shorter than the debounce window
        start_test();
        for (int i = 0; i < 17; i++) cycle((i < 3 || (i >= 4 && i < 7)) ? 3'b001 : 3'b000, "t2");
        e = {}; chk_q("t2.press0", q_press[0], e);
        chk_q("t2.rpt0", q_rpt[0], e);
        chk("t2.dpb0_cycles", 32'(cnt_dpb[0]), 32'd0);

        // 3: 2-cycle dropout while held
        start_test();
        for (int i = 0; i < 45; i++) cycle((i < 8 || (i >= 10 && i < 30)) ? 3'b001 : 3'b000, "t3");
        e = {6, 18, 23, 28}; chk_q("t3.rpt0", q_rpt[0], e);
        e = {36};            chk_q("t3.rel0", q_rel[0], e);
        chk("t3.dpb0_cycles", 32'(cnt_dpb[0]), 32'd30);

        // 4: ch0 and ch1 pressed together
        start_test();
        for (int i = 0; i < 40; i++) cycle((i < 25) ? 3'b011 : 3'b000, "t4");
        e = {6};             chk_q("t4.press0", q_press[0], e);
        chk_q("t4.press1", q_press[1], e);
        chk_q("t4.rpt1", q_rpt[1], e);
        e = {6, 16, 21, 26}; chk_q("t4.rpt0", q_rpt[0], e);
        e = {31};            chk_q("t4.rel1", q_rel[1], e);

        // 5: reset while ch2 held, button kept down across reset
        start_test();
        for (int i = 0; i < 10; i++) cycle(3'b100, "t5a");
        chk("t5.pre_dpb2", 32'(dpb[2]), 32'd1);
        apply_reset("t5");
        clear_log();
        for (int i = 0; i < 12; i++) cycle(3'b100, "t5b");
        e = {6}; chk_q("t5.press2", q_press[2], e);
        e = {};  chk_q("t5.rel2", q_rel[2], e);

        // 6: long hold
        start_test();
        for (int i = 0; i < 50; i++) cycle((i < 40) ? 3'b001 : 3'b000, "t6");
`ifdef BTN_LONGPRESS_EN
        e = {26};
`else
        e = {};
`endif
        chk_q("t6.long0", q_lng[0], e);

        // Random phase: independent toggling per channel, mixed short/long holds
        rb = '0;
        for (int c = 0; c < N_CH; c++) hold_left[c] = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (hold_left[c] == 0) begin
                    rb[c] = ~rb[c];
                    hold_left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                               : $urandom_range(5, 40);
                end
                hold_left[c]--;
            end
            if ($urandom_range(0, 499) == 0) apply_reset("rnd");
            cycle(rb, "rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
